// File: rtl/axi_bridge.sv
// axi_bridge: single-outstanding AXI master shared by the instruction and data caches.
//
// Captures fetch and data requests into pending flags, arbitrates between them (data wins
// ties), issues each request as one single-beat AXI read or write, and returns the result
// as a one-cycle return_ready pulse to the owning client.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   inst_interface_*               fetch request (call_begin/addr) and response (return_ready/rdata)
//   data_interface_*, write_enable data request (enable/call_begin/addresses/wdata/sizes) and
//   read_size, write_size          response (return_ready/rdata, 0 for writes)
//   ar*/r*/aw*/w*/b*               AXI master channels, single beat, one transaction in flight
module axi_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_interface_call_begin,
    input  logic [31:0] inst_interface_addr,
    output logic        inst_interface_return_ready,
    output logic [31:0] inst_interface_rdata,
    input  logic        data_interface_enable,
    input  logic        write_enable,
    input  logic [2:0]  read_size,
    input  logic [2:0]  write_size,
    input  logic [31:0] data_interface_raddr,
    input  logic [31:0] data_interface_waddr,
    input  logic [31:0] data_interface_wdata,
    input  logic        data_interface_call_begin,
    output logic        data_interface_return_ready,
    output logic [31:0] data_interface_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam logic [3:0] INST_ID = 4'h0;
    localparam logic [3:0] DATA_ID = 4'h1;

    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW_W, WR_B, RESP} state_t;

    state_t      r_state;
    logic        r_owner_data;
    logic        r_is_write;
    logic [31:0] r_rdata_buf;
    logic        r_inst_pend;
    logic [31:0] r_inst_addr;
    logic        r_data_pend;
    logic        r_data_we;
    logic [31:0] r_data_raddr;
    logic [31:0] r_data_waddr;
    logic [2:0]  r_data_rsize;
    logic [2:0]  r_data_wsize;
    logic [31:0] r_data_wdata;

    // Single transaction in flight: IDs and responses carry no information.
    logic w_unused;
    assign w_unused = ^{rid, rresp, rlast, bid, bresp};

    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = awid;
    assign wlast   = 1'b1;

    function automatic logic [2:0] clamp_size(input logic [2:0] s);
        return (s > 3'd2) ? 3'd2 : s;
    endfunction

    function automatic logic [3:0] strobe(input logic [2:0] s, input logic [1:0] a);
        logic [3:0] st;
        case (clamp_size(s))
            3'd0:    st = 4'b0001 << a;
            3'd1:    st = 4'b0011 << {a[1], 1'b0};
            default: st = 4'hF;
        endcase
        return st;
    endfunction

    // A client is "in flight" while its transaction occupies the bus; RESP is excluded so a
    // request arriving during the response cycle is still captured.
    logic w_busy;
    logic w_inst_accept;
    logic w_data_accept;
    assign w_busy        = (r_state != IDLE) && (r_state != RESP);
    assign w_inst_accept = inst_interface_call_begin && !r_inst_pend && !(w_busy && !r_owner_data);
    assign w_data_accept = data_interface_call_begin && data_interface_enable && !r_data_pend &&
                           !(w_busy && r_owner_data);

    // Issue from IDLE uses the live inputs when the request arrives in the same cycle.
    logic        w_d_we;
    logic [31:0] w_d_raddr;
    logic [31:0] w_d_waddr;
    logic [2:0]  w_d_rsize;
    logic [2:0]  w_d_wsize;
    logic [31:0] w_d_wdata;
    logic [31:0] w_i_addr;
    assign w_d_we    = r_data_pend ? r_data_we    : write_enable;
    assign w_d_raddr = r_data_pend ? r_data_raddr : data_interface_raddr;
    assign w_d_waddr = r_data_pend ? r_data_waddr : data_interface_waddr;
    assign w_d_rsize = r_data_pend ? r_data_rsize : read_size;
    assign w_d_wsize = r_data_pend ? r_data_wsize : write_size;
    assign w_d_wdata = r_data_pend ? r_data_wdata : data_interface_wdata;
    assign w_i_addr  = r_inst_pend ? r_inst_addr  : inst_interface_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state                     <= IDLE;
            r_owner_data                <= 1'b0;
            r_is_write                  <= 1'b0;
            r_rdata_buf                 <= 32'd0;
            r_inst_pend                 <= 1'b0;
            r_inst_addr                 <= 32'd0;
            r_data_pend                 <= 1'b0;
            r_data_we                   <= 1'b0;
            r_data_raddr                <= 32'd0;
            r_data_waddr                <= 32'd0;
            r_data_rsize                <= 3'd0;
            r_data_wsize                <= 3'd0;
            r_data_wdata                <= 32'd0;
            inst_interface_return_ready <= 1'b0;
            inst_interface_rdata        <= 32'd0;
            data_interface_return_ready <= 1'b0;
            data_interface_rdata        <= 32'd0;
            arid                        <= 4'd0;
            araddr                      <= 32'd0;
            arsize                      <= 3'd0;
            arvalid                     <= 1'b0;
            rready                      <= 1'b0;
            awid                        <= 4'd0;
            awaddr                      <= 32'd0;
            awsize                      <= 3'd0;
            awvalid                     <= 1'b0;
            wdata                       <= 32'd0;
            wstrb                       <= 4'd0;
            wvalid                      <= 1'b0;
            bready                      <= 1'b0;
        end else begin
            inst_interface_return_ready <= 1'b0;
            data_interface_return_ready <= 1'b0;

            if (w_inst_accept) begin
                r_inst_pend <= 1'b1;
                r_inst_addr <= inst_interface_addr;
            end
            if (w_data_accept) begin
                r_data_pend  <= 1'b1;
                r_data_we    <= write_enable;
                r_data_raddr <= data_interface_raddr;
                r_data_waddr <= data_interface_waddr;
                r_data_rsize <= read_size;
                r_data_wsize <= write_size;
                r_data_wdata <= data_interface_wdata;
            end

            case (r_state)
                IDLE: begin
                    // Later assignments to the pend flags override the capture above.
                    if (r_data_pend || w_data_accept) begin
                        r_owner_data <= 1'b1;
                        r_data_pend  <= 1'b0;
                        r_is_write   <= w_d_we;
                        if (w_d_we) begin
                            awid    <= DATA_ID;
                            awaddr  <= w_d_waddr;
                            awsize  <= clamp_size(w_d_wsize);
                            awvalid <= 1'b1;
                            wdata   <= w_d_wdata;
                            wstrb   <= strobe(w_d_wsize, w_d_waddr[1:0]);
                            wvalid  <= 1'b1;
                            r_state <= WR_AW_W;
                        end else begin
                            arid    <= DATA_ID;
                            araddr  <= w_d_raddr;
                            arsize  <= clamp_size(w_d_rsize);
                            arvalid <= 1'b1;
                            r_state <= RD_AR;
                        end
                    end else if (r_inst_pend || w_inst_accept) begin
                        r_owner_data <= 1'b0;
                        r_inst_pend  <= 1'b0;
                        r_is_write   <= 1'b0;
                        arid         <= INST_ID;
                        araddr       <= w_i_addr;
                        arsize       <= 3'd2;
                        arvalid      <= 1'b1;
                        r_state      <= RD_AR;
                    end
                end
                RD_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        r_state <= RD_R;
                    end
                end
                RD_R: begin
                    if (rvalid) begin
                        rready      <= 1'b0;
                        r_rdata_buf <= rdata;
                        r_state     <= RESP;
                    end
                end
                WR_AW_W: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        bready  <= 1'b1;
                        r_state <= WR_B;
                    end
                end
                WR_B: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (r_owner_data) begin
                        data_interface_return_ready <= 1'b1;
                        data_interface_rdata        <= r_is_write ? 32'd0 : r_rdata_buf;
                    end else begin
                        inst_interface_return_ready <= 1'b1;
                        inst_interface_rdata        <= r_rdata_buf;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
